// File: rtl/tetris_pkg.sv
// Shared Tetris board geometry, colour codes and the row-prefetch FSM state type.
// Pure declarations, no latency; no flow control.
// Imported by board_mem_arbiter and board_row_buffer.
package tetris_pkg;

    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int COLOR_W = 3;
    localparam int COL_W   = $clog2(COLS);

    localparam logic [COLOR_W-1:0] CLR_EMPTY    = 3'd0;
    localparam logic [COLOR_W-1:0] CLR_I_CYAN   = 3'd1;
    localparam logic [COLOR_W-1:0] CLR_O_YELLOW = 3'd2;
    localparam logic [COLOR_W-1:0] CLR_S_GREEN  = 3'd3;
    localparam logic [COLOR_W-1:0] CLR_Z_RED    = 3'd4;
    localparam logic [COLOR_W-1:0] CLR_T_PURPLE = 3'd5;
    localparam logic [COLOR_W-1:0] CLR_L_ORANGE = 3'd6;
    localparam logic [COLOR_W-1:0] CLR_J_BLUE   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/board_row_buffer.sv
// Back/front row buffers: per-cell capture into back, atomic back->front publish, display read.
// Capture/copy take effect on the next edge; disp_color is combinational from front.
// No backpressure: every capture/copy request is accepted in the cycle it is presented.
module board_row_buffer
    import tetris_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr_back,
    input  logic               cap_vld,
    input  logic [COL_W-1:0]   cap_col,
    input  logic [COLOR_W-1:0] cap_dat,
    input  logic               copy,
    input  logic [3:0]         disp_col,
    output logic [COLOR_W-1:0] disp_color
);

    logic [COLS-1:0][COLOR_W-1:0] back_q, back_d;
    logic [COLS-1:0][COLOR_W-1:0] front_q, front_d;

    // front copies the post-capture back image so the last cell lands in the same edge
    always_comb begin
        back_d = back_q;
        if (clr_back) begin
            back_d = '0;
        end else if (cap_vld) begin
            back_d[cap_col] = cap_dat;
        end
        front_d = copy ? back_d : front_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            back_q  <= '0;
            front_q <= '0;
        end else begin
            back_q  <= back_d;
            front_q <= front_d;
        end
    end

    always_comb begin
        disp_color = '0;
        if (disp_col < 4'(COLS)) begin
            disp_color = front_q[disp_col];
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board RAM port arbiter: CPU load/store has absolute priority, a row prefetcher uses idle cycles.
// Row fetch latency COLS+2 cycles from line_req to fetch_done, +1 per cycle taken by the CPU.
// CPU is never stalled; BOARD_ARB_STATS_EN adds stall_cnt counting prefetch cycles lost to the CPU.
module board_mem_arbiter
    import tetris_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               line_req,
    input  logic [4:0]         line_row,
    output logic               fetch_busy,
    output logic               fetch_done,
    output logic               fetch_overrun,
`ifdef BOARD_ARB_STATS_EN
    output logic [15:0]        stall_cnt,
`endif
    input  logic [3:0]         disp_col,
    output logic [COLOR_W-1:0] disp_color
);

    arb_state_e         state_q, state_d;
    logic [4:0]         row_q, row_d;
    logic [COL_W-1:0]   col_ptr_q, col_ptr_d;
    logic               pipe_v_q, pipe_v_d;
    logic [COL_W-1:0]   pipe_col_q, pipe_col_d;
    logic               fetch_done_q, fetch_done_d;
    logic               overrun_q, overrun_d;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               copy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_ptr_q    <= '0;
            pipe_v_q     <= 1'b0;
            pipe_col_q   <= '0;
            fetch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_ptr_q    <= col_ptr_d;
            pipe_v_q     <= pipe_v_d;
            pipe_col_q   <= pipe_col_d;
            fetch_done_q <= fetch_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // A new line_req always wins: it restarts the fetch and suppresses any pending publish.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_ptr_d    = col_ptr_q;
        pipe_v_d     = 1'b0;
        pipe_col_d   = pipe_col_q;
        fetch_done_d = 1'b0;
        overrun_d    = overrun_q;
        if (line_req) begin
            row_d     = line_row;
            col_ptr_d = '0;
            state_d   = (line_row < 5'(ROWS)) ? ST_ISSUE : ST_CLEAR;
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (!cpu_req) begin
                        pipe_v_d   = 1'b1;
                        pipe_col_d = col_ptr_q;
                        col_ptr_d  = col_ptr_q + 1'b1;
                        if (col_ptr_q == COL_W'(COLS - 1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN, ST_CLEAR: begin
                    state_d      = ST_IDLE;
                    fetch_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fetch_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_ptr_q);
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (state_q == ST_ISSUE) begin
            mem_addr = fetch_addr;
        end
        fetch_busy = (state_q != ST_IDLE);
        copy       = !line_req && ((state_q == ST_DRAIN) || (state_q == ST_CLEAR));
    end

    assign cpu_rdata     = mem_rdata;
    assign fetch_done    = fetch_done_q;
    assign fetch_overrun = overrun_q;

    board_row_buffer u_row_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_back   (line_req),
        .cap_vld    (pipe_v_q),
        .cap_col    (pipe_col_q),
        .cap_dat    (mem_rdata[COLOR_W-1:0]),
        .copy       (copy),
        .disp_col   (disp_col),
        .disp_color (disp_color)
    );

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (line_req) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_ISSUE) && cpu_req && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: directed fetch table, restart/reset sequences,
// then randomized fetches with CPU traffic checked against a cycle-count reference model.
module tb_board_mem_arbiter;
    import tetris_pkg::*;

    localparam int ADDR_W = 12;
    localparam int BASE   = 0;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              line_req = 1'b0;
    logic [4:0]        line_row = '0;
    logic              fetch_busy;
    logic              fetch_done;
    logic              fetch_overrun;
    logic [3:0]        disp_col = '0;
    logic [COLOR_W-1:0] disp_color;
`ifdef BOARD_ARB_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    board_mem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .line_req      (line_req),
        .line_row      (line_row),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .fetch_overrun (fetch_overrun),
`ifdef BOARD_ARB_STATS_EN
        .stall_cnt     (stall_cnt),
`endif
        .disp_col      (disp_col),
        .disp_color    (disp_color)
    );

    // Board RAM: cell k holds k%8 until written; 1-cycle read latency, read-before-write.
    logic [31:0] wr_ovl [int];

    function automatic logic [31:0] ram_rd(input int a);
        if (wr_ovl.exists(a)) return wr_ovl[a];
        return 32'(a % 8);
    endfunction

    always @(posedge clock) begin
        mem_rdata <= ram_rd(int'(mem_addr));
        if (mem_we) wr_ovl[int'(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_front(input int row);
        logic [31:0] w;
        logic [COLOR_W-1:0] e;
        line_req = 1'b0;
        cpu_req  = 1'b0;
        for (int c = 0; c < 16; c++) begin
            disp_col = 4'(c);
            @(negedge clock);
            w = ram_rd(BASE + row * COLS + c);
            e = (row < ROWS && c < COLS) ? w[COLOR_W-1:0] : '0;
            chk("disp_color", disp_color, e);
            @(posedge clock); #1;
        end
    endtask

    // One row fetch from line_req (cycle 0) to one cycle past fetch_done; per-cycle port model.
    task automatic run_fetch(input int row, input bit use_mask, input logic [31:0] mask,
                             input int pct, input int exp_tab);
        int issued = 0;
        int exp_done;
        bit ended = 0;
        bit in_rng;
        logic [ADDR_W-1:0] ea;
        logic ewe;
        logic [31:0] ewd;
        in_rng   = (row < ROWS);
        exp_done = use_mask ? exp_tab : (in_rng ? -1 : 2);
        for (int k = 0; k < 80; k++) begin
            line_req = (k == 0);
            line_row = 5'(row);
            if (k == 0) cpu_req = 1'b0;
            else if (use_mask) cpu_req = (k < 32) ? mask[k] : 1'b0;
            else cpu_req = ($urandom_range(99) < pct);
            if (use_mask) begin
                cpu_addr = 12'd100; cpu_we = 1'b1; cpu_wdata = 32'd7;
            end else begin
                cpu_addr = 12'($urandom_range(4095, 200));
                cpu_we = 1'($urandom_range(1)); cpu_wdata = $urandom;
            end
            @(negedge clock);
            if (cpu_req) begin
                ea = cpu_addr; ewe = cpu_we; ewd = cpu_wdata;
            end else if (in_rng && k >= 1 && issued < COLS) begin
                ea = 12'(BASE + row * COLS + issued); ewe = 1'b0; ewd = '0;
                issued++;
                if (issued == COLS && !use_mask) exp_done = k + 2;
            end else begin
                ea = '0; ewe = 1'b0; ewd = '0;
            end
            chk("mem_port", {mem_addr, mem_we, mem_wdata}, {ea, ewe, ewd});
            chk("fetch_done", fetch_done, k == exp_done);
            if (exp_done >= 0 && k > exp_done) begin
                ended = 1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!ended) begin
            n_vec++; n_err++;
            $display("FAIL fetch_timeout: row %0d never completed", row);
        end
        chk("cpu_rdata", cpu_rdata, mem_rdata);
        @(posedge clock); #1;
        line_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clock);
        chk("busy_after", fetch_busy, 1'b0);
        @(posedge clock); #1;
        check_front(row);
    endtask

    // Second line_req at cycle kb restarts the fetch; front must hold the old row until kb+12.
    task automatic hand_restart(input int ra, input int rb, input int kb,
                                input logic [2:0] old_c0, input logic [2:0] new_c0,
                                input bit ov_before);
        for (int k = 0; k <= kb + 13; k++) begin
            line_req = (k == 0) || (k == kb);
            line_row = 5'((k < kb) ? ra : rb);
            cpu_req  = 1'b0;
            disp_col = 4'd0;
            @(negedge clock);
            chk("restart_done", fetch_done, k == kb + 12);
            chk("restart_front", disp_color, (k >= kb + 12) ? new_c0 : old_c0);
            chk("overrun", fetch_overrun, ov_before || (k > kb));
            @(posedge clock); #1;
        end
        line_req = 1'b0;
        check_front(rb);
    endtask

    typedef struct {
        int          row;
        logic [31:0] mask;
        int          exp_done;
    } fvec_t;

    fvec_t tbl [9];

    initial begin
        tbl[0] = '{3,  32'h0,   12};
        tbl[1] = '{3,  32'h24,  14};
        tbl[2] = '{0,  32'h0,   12};
        tbl[3] = '{19, 32'hE,   15};
        tbl[4] = '{25, 32'h0,   2};
        tbl[5] = '{20, 32'h2,   2};
        tbl[6] = '{7,  32'h406, 15};
        tbl[7] = '{31, 32'h0,   2};
        tbl[8] = '{1,  32'h0,   12};

        @(negedge clock);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_done", fetch_done, 1'b0);
        chk("rst_overrun", fetch_overrun, 1'b0);
        chk("rst_color", disp_color, '0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            run_fetch(tbl[i].row, 1'b1, tbl[i].mask, 0, tbl[i].exp_done);
`ifdef BOARD_ARB_STATS_EN
            if (i == 1) chk("stall_cnt", stall_cnt, 16'd2);
`endif
        end

        hand_restart(3, 4, 5, 3'd2, 3'd0, 1'b0);
        hand_restart(5, 6, 11, 3'd0, 3'd4, 1'b1);

        line_req = 1'b1; line_row = 5'd3; cpu_req = 1'b0; disp_col = 4'd0;
        @(posedge clock); #1;
        line_req = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("pre_reset_addr", mem_addr, 12'd33);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_mem_addr", mem_addr, '0);
        chk("arst_busy", fetch_busy, 1'b0);
        chk("arst_done", fetch_done, 1'b0);
        chk("arst_overrun", fetch_overrun, 1'b0);
        chk("arst_color", disp_color, '0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_fetch(3, 1'b1, 32'h0, 0, 12);

        for (int e = 0; e < 40; e++) begin
            run_fetch(int'($urandom_range(0, 24)), 1'b0, 32'h0, int'($urandom_range(0, 60)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
